// File: rtl/ren_pkg.sv
// Shared renderer definitions: arbitration FSM states, tile source
// encoding and the fixed tile size stamped on binner entries.
package ren_pkg;

    typedef enum logic {
        R_PRI   = 1'b0,
        B_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic {
        SRC_BIN = 1'b0,
        SRC_RAS = 1'b1
    } src_e;

    localparam int BIN_TILE_SIZE = 16;

endpackage

// File: rtl/ren_tile_sched_if.sv
// Tile scheduler bus: binner and rasterizer request channels plus the
// queue write port. Stats outputs exist only with REN_SCHED_STATS_EN.
interface ren_tile_sched_if #(
    parameter int TW = 8,
    parameter int SW = 6
);
    logic [TW-1:0] i_tile_x_b, i_tile_y_b;
    logic          i_valid_b, o_ready_b;

    logic [TW-1:0] i_tile_x_r, i_tile_y_r;
    logic [SW-1:0] i_tile_size_r;
    logic          i_valid_r, o_ready_r;

    logic [TW-1:0] o_tile_x, o_tile_y;
    logic [SW-1:0] o_tile_size;
    logic          o_src, o_push, i_full;

`ifdef REN_SCHED_STATS_EN
    logic [15:0]   o_cnt_b, o_cnt_r;

    modport slave (
        input  i_tile_x_b, i_tile_y_b, i_valid_b, i_tile_x_r, i_tile_y_r,
               i_tile_size_r, i_valid_r, i_full,
        output o_ready_b, o_ready_r, o_tile_x, o_tile_y, o_tile_size,
               o_src, o_push, o_cnt_b, o_cnt_r
    );
    modport master (
        output i_tile_x_b, i_tile_y_b, i_valid_b, i_tile_x_r, i_tile_y_r,
               i_tile_size_r, i_valid_r, i_full,
        input  o_ready_b, o_ready_r, o_tile_x, o_tile_y, o_tile_size,
               o_src, o_push, o_cnt_b, o_cnt_r
    );
`else
    modport slave (
        input  i_tile_x_b, i_tile_y_b, i_valid_b, i_tile_x_r, i_tile_y_r,
               i_tile_size_r, i_valid_r, i_full,
        output o_ready_b, o_ready_r, o_tile_x, o_tile_y, o_tile_size,
               o_src, o_push
    );
    modport master (
        output i_tile_x_b, i_tile_y_b, i_valid_b, i_tile_x_r, i_tile_y_r,
               i_tile_size_r, i_valid_r, i_full,
        input  o_ready_b, o_ready_r, o_tile_x, o_tile_y, o_tile_size,
               o_src, o_push
    );
`endif

endinterface

// File: rtl/ren_tile_sched_arb.sv
// Rasterizer-priority arbiter with binner anti-starvation: after
// MAX_BURST consecutive rasterizer grants while the binner waited, the
// binner is forced through once.
module ren_tile_sched_arb
    import ren_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_b,
    input  logic valid_r,
    input  logic can_grant,
    output logic ready_b,
    output logic ready_r
);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    // State and starve counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_PRI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Grant selection and next state; everything holds while no grant is possible
    always_comb begin
        ready_b   = 1'b0;
        ready_r   = 1'b0;
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        if (can_grant) begin
            case (state_q)
                R_PRI: begin
                    if (valid_r) ready_r = 1'b1;
                    else         ready_b = 1'b1;
                    // Only a rasterizer win over a waiting binner counts as starvation
                    if (valid_r && valid_b) cnt_nxt = cnt_q + 1'b1;
                    else                    cnt_nxt = '0;
                    if (cnt_nxt == CW'(MAX_BURST)) state_nxt = B_FORCE;
                end
                B_FORCE: begin
                    // Either the binner transfers now or it has withdrawn
                    ready_b   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = R_PRI;
                end
                default: state_nxt = R_PRI;
            endcase
        end
    end

endmodule

// File: rtl/ren_tile_sched.sv
// Tile scheduler: merges binner and rasterizer tile requests into a
// single-entry output register feeding the tile queue.
// Optional per-source push counters: REN_SCHED_STATS_EN.
module ren_tile_sched
    import ren_pkg::*;
#(
    parameter int TW        = 8,
    parameter int SW        = 6,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ren_tile_sched_if.slave           bus
);
    logic          out_vld;
    logic [TW-1:0] out_x, out_y;
    logic [SW-1:0] out_size;
    src_e          out_src;
    logic          rst_q;
    logic          push, can_grant, ready_b, ready_r;

    // Queue writes whenever an entry is held and there is room; reset discards it
    assign push      = out_vld & ~bus.i_full & ~rst;
    // Grants stay off during reset and the cycle after it
    assign can_grant = (~out_vld | push) & ~rst & ~rst_q;

    ren_tile_sched_arb #(.MAX_BURST(MAX_BURST)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid_b   (bus.i_valid_b),
        .valid_r   (bus.i_valid_r),
        .can_grant (can_grant),
        .ready_b   (ready_b),
        .ready_r   (ready_r)
    );

    assign bus.o_ready_b   = ready_b;
    assign bus.o_ready_r   = ready_r;
    assign bus.o_push      = push;
    assign bus.o_tile_x    = out_x;
    assign bus.o_tile_y    = out_y;
    assign bus.o_tile_size = out_size;
    assign bus.o_src       = out_src;

    // Delayed reset keeps the readies low for one cycle after reset
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Output entry: load on transfer (may overlap a push), clear on push alone
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_size <= '0;
            out_src  <= SRC_BIN;
        end else if (ready_r && bus.i_valid_r) begin
            out_vld  <= 1'b1;
            out_x    <= bus.i_tile_x_r;
            out_y    <= bus.i_tile_y_r;
            out_size <= bus.i_tile_size_r;
            out_src  <= SRC_RAS;
        end else if (ready_b && bus.i_valid_b) begin
            out_vld  <= 1'b1;
            out_x    <= bus.i_tile_x_b;
            out_y    <= bus.i_tile_y_b;
            out_size <= SW'(BIN_TILE_SIZE);
            out_src  <= SRC_BIN;
        end else if (push) begin
            out_vld  <= 1'b0;
        end
    end

`ifdef REN_SCHED_STATS_EN
    logic [15:0] cnt_b, cnt_r;

    // Saturating per-source push counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_b <= '0;
            cnt_r <= '0;
        end else if (push) begin
            if (out_src == SRC_RAS) begin
                if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
            end else begin
                if (cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
            end
        end
    end

    assign bus.o_cnt_b = cnt_b;
    assign bus.o_cnt_r = cnt_r;
`endif

endmodule

// File: tb/tb_ren_tile_sched.sv
// Self-checking bench for ren_tile_sched: directed scenarios plus a
// randomized run, all compared against a cycle-level reference model.
module tb_ren_tile_sched;
    localparam int TW        = 8;
    localparam int SW        = 6;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ren_tile_sched_if #(.TW(TW), .SW(SW)) bus ();

    ren_tile_sched #(.TW(TW), .SW(SW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_vld, m_src, m_owed, m_post;
    int            m_streak;
    logic [TW-1:0] m_x, m_y;
    logic [SW-1:0] m_size;
    int            m_cnt_b, m_cnt_r;

    // Observations of the most recent cycle
    bit            last_push, last_rb, last_rr;
    logic [TW-1:0] last_x, last_y;
    logic [SW-1:0] last_size;
    bit            last_src;
    string         last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance model at posedge
    task automatic cycle(input bit r, input bit vb, input bit vr, input bit full,
                         input logic [TW-1:0] bx, input logic [TW-1:0] by,
                         input logic [TW-1:0] rx, input logic [TW-1:0] ry,
                         input logic [SW-1:0] rs);
        bit e_push, e_can, e_rb, e_rr;
        rst               = r;
        bus.i_valid_b     = vb;
        bus.i_valid_r     = vr;
        bus.i_full        = full;
        bus.i_tile_x_b    = bx;
        bus.i_tile_y_b    = by;
        bus.i_tile_x_r    = rx;
        bus.i_tile_y_r    = ry;
        bus.i_tile_size_r = rs;
        @(negedge clk);
        e_push = m_vld && !full && !r;
        e_can  = (!m_vld || e_push) && !r && !m_post;
        e_rb   = e_can && (m_owed || !vr);
        e_rr   = e_can && !m_owed && vr;
        chk("push", bus.o_push, e_push);
        chk("ready_b", bus.o_ready_b, e_rb);
        chk("ready_r", bus.o_ready_r, e_rr);
        if (e_push) begin
            chk("push_x", bus.o_tile_x, m_x);
            chk("push_y", bus.o_tile_y, m_y);
            chk("push_size", bus.o_tile_size, m_size);
            chk("push_src", bus.o_src, m_src);
        end
`ifdef REN_SCHED_STATS_EN
        if (!r) begin
            chk("cnt_b", bus.o_cnt_b, m_cnt_b);
            chk("cnt_r", bus.o_cnt_r, m_cnt_r);
        end
`endif
        last_push  = bus.o_push;
        last_rb    = bus.o_ready_b;
        last_rr    = bus.o_ready_r;
        last_x     = bus.o_tile_x;
        last_y     = bus.o_tile_y;
        last_size  = bus.o_tile_size;
        last_src   = bus.o_src;
        last_grant = "-";
        if (r) begin
            m_vld = 0; m_owed = 0; m_streak = 0; m_post = 1;
            m_cnt_b = 0; m_cnt_r = 0;
        end else begin
            m_post = 0;
            if (e_push) begin
                m_vld = 0;
                if (m_src) m_cnt_r = (m_cnt_r < 65535) ? m_cnt_r + 1 : 65535;
                else       m_cnt_b = (m_cnt_b < 65535) ? m_cnt_b + 1 : 65535;
            end
            if (e_rr && vr) begin
                m_vld = 1; m_x = rx; m_y = ry; m_size = rs; m_src = 1; last_grant = "R";
            end else if (e_rb && vb) begin
                m_vld = 1; m_x = bx; m_y = by; m_size = 16; m_src = 0; last_grant = "B";
            end
            if (e_can) begin
                if (m_owed) begin
                    m_owed = 0; m_streak = 0;
                end else if (vr && vb) begin
                    m_streak++;
                    if (m_streak == MAX_BURST) begin
                        m_owed = 1; m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit full);
        cycle(0, 0, 0, full, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
    endtask

    initial begin
        string seq;
        @(posedge clk);
        #1;

        // Reset state: nothing pushed, no ready in or right after reset
        do_reset();
        chk("post_rst_push", last_push, 0);
        chk("post_rst_rdy_b", last_rb, 0);
        chk("post_rst_rdy_r", last_rr, 0);

        // Binner only: (3,5) granted, pushed next cycle with size 16
        cycle(0, 1, 0, 0, 8'd3, 8'd5, 0, 0, 0);
        chk("bin_ready", last_rb, 1);
        idle(0);
        chk("bin_push", last_push, 1);
        chk("bin_x", last_x, 3);
        chk("bin_y", last_y, 5);
        chk("bin_size", last_size, 16);
        chk("bin_src", last_src, 0);
        idle(0);

        // Both requesting: four rasterizer grants then a forced binner grant
        do_reset();
        seq = "";
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1, 0, 8'(i), 8'(i), 8'(i + 100), 8'(i), 6'd4);
            seq = {seq, last_grant};
        end
        chk_str("burst_seq", seq, "RRRRBRRRRB");
        idle(0);
        idle(0);

        // Queue full for 5 cycles: entry held, readies off, one push on release
        cycle(0, 1, 0, 1, 8'h2A, 8'h11, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 6'd5);
            chk("full_push", last_push, 0);
            chk("full_rdy_b", last_rb, 0);
            chk("full_rdy_r", last_rr, 0);
            chk("full_x", last_x, 8'h2A);
            chk("full_y", last_y, 8'h11);
        end
        idle(0);
        chk("release_push", last_push, 1);
        chk("release_x", last_x, 8'h2A);
        idle(0);
        chk("release_once", last_push, 0);

        // Rasterizer stream of size 8: one push per cycle, no bubbles
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 8'(i + 1), 8'(i + 2), 6'd8);
            if (i > 0) begin
                chk("stream_push", last_push, 1);
                chk("stream_x", last_x, i);
                chk("stream_size", last_size, 8);
                chk("stream_src", last_src, 1);
            end
        end
        idle(0);
        chk("stream_last_x", last_x, 8);

        // Reset with an entry held: it is discarded, arbitration restarts
        cycle(0, 1, 0, 1, 8'h77, 8'h66, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_drop_push", last_push, 0);
        idle(0);
        chk("rst_after_push", last_push, 0);
        idle(0);
        chk("rst_idle_push", last_push, 0);
`ifdef REN_SCHED_STATS_EN
        chk("rst_cnt_b", bus.o_cnt_b, 0);
        chk("rst_cnt_r", bus.o_cnt_r, 0);
`endif
        seq = "";
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 0, 8'(i), 0, 8'(i), 0, 6'd1);
            seq = {seq, last_grant};
        end
        chk_str("rst_fsm_seq", seq, "RRRRB");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  6'($urandom));
        end

`ifdef REN_SCHED_STATS_EN
        // Binner counter saturation
        do_reset();
        for (int i = 0; i < 70002; i++) begin
            cycle(0, 1, 0, 0, 8'(i), 8'(i), 0, 0, 0);
        end
        chk("sat_cnt_b", bus.o_cnt_b, 16'hFFFF);
        chk("sat_cnt_r", bus.o_cnt_r, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
